// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU result checker.
// Flag vectors are {carry, zero, valid, slt}; fail_fields is {data, carry, zero, valid, slt}.
package alu_pkg;
    localparam int WIDTH_DEF  = 8;
    localparam int OPCODE_DEF = 3;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_VALID = 1;
    localparam int FLAG_SLT   = 0;

    localparam int FF_DATA  = 4;
    localparam int FF_CARRY = 3;
    localparam int FF_ZERO  = 2;
    localparam int FF_VALID = 1;
    localparam int FF_SLT   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/alu_cmp_stage.sv
// Registered compare of one DUT/golden result pair; the verdict and the vector's
// index/opcode appear one cycle after the accept edge.
module alu_cmp_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int OPCODE = OPCODE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic [15:0]       in_idx,
    input  logic [OPCODE-1:0] in_op,
    input  logic [WIDTH-1:0]  dut_data,
    input  logic [WIDTH-1:0]  gold_data,
    input  logic [3:0]        dut_flags,
    input  logic [3:0]        gold_flags,
    output logic              cmp_valid,
    output logic              cmp_mismatch,
    output logic [4:0]        cmp_fields,
    output logic [15:0]       cmp_idx,
    output logic [OPCODE-1:0] cmp_op
);
    logic              valid_q, valid_d;
    logic              mismatch_q, mismatch_d;
    logic [4:0]        fields_q, fields_d;
    logic [15:0]       idx_q, idx_d;
    logic [OPCODE-1:0] op_q, op_d;

    always_comb begin
        valid_d  = accept;
        fields_d = '0;
        fields_d[FF_DATA]  = (dut_data != gold_data);
        fields_d[FF_CARRY] = (dut_flags[FLAG_CARRY] != gold_flags[FLAG_CARRY]);
        fields_d[FF_ZERO]  = (dut_flags[FLAG_ZERO]  != gold_flags[FLAG_ZERO]);
        fields_d[FF_VALID] = (dut_flags[FLAG_VALID] != gold_flags[FLAG_VALID]);
        fields_d[FF_SLT]   = (dut_flags[FLAG_SLT]   != gold_flags[FLAG_SLT]);
        mismatch_d = |fields_d;
        idx_d = accept ? in_idx : idx_q;
        op_d  = accept ? in_op  : op_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            fields_q   <= '0;
            idx_q      <= '0;
            op_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
            fields_q   <= fields_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
        end
    end

    assign cmp_valid    = valid_q;
    assign cmp_mismatch = mismatch_q;
    assign cmp_fields   = fields_q;
    assign cmp_idx      = idx_q;
    assign cmp_op       = op_q;
endmodule

// File: rtl/alu_result_checker.sv
// Run controller: accepts num_vectors result pairs, tallies matches/mismatches from
// the registered compare stage and records the first failing vector.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int OPCODE = OPCODE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       num_vectors,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPCODE-1:0] in_op,
    input  logic [WIDTH-1:0]  dut_data,
    input  logic [WIDTH-1:0]  gold_data,
    input  logic [3:0]        dut_flags,
    input  logic [3:0]        gold_flags,
    output logic [15:0]       match_count,
    output logic [15:0]       mismatch_count,
    output logic [4:0]        fail_fields,
    output logic              first_fail_valid,
    output logic [15:0]       first_fail_idx,
    output logic [OPCODE-1:0] first_fail_op,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        state_dbg
);
    // Handshake: a pair transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, and in_valid may drop at any time to stall.
    state_t            state_q, state_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       acc_cnt_q, acc_cnt_d;
    logic [15:0]       match_q, match_d;
    logic [15:0]       mism_q, mism_d;
    logic [4:0]        fields_q, fields_d;
    logic              ffv_q, ffv_d;
    logic [15:0]       ffidx_q, ffidx_d;
    logic [OPCODE-1:0] ffop_q, ffop_d;

    logic              accept;
    logic              cmp_valid, cmp_mismatch;
    logic [4:0]        cmp_fields;
    logic [15:0]       cmp_idx;
    logic [OPCODE-1:0] cmp_op;

    assign accept = (state_q == ST_RUN) && in_valid;

    alu_cmp_stage #(.WIDTH(WIDTH), .OPCODE(OPCODE)) u_cmp (
        .clk          (clk),
        .rst_n        (rst_n),
        .accept       (accept),
        .in_idx       (acc_cnt_q),
        .in_op        (in_op),
        .dut_data     (dut_data),
        .gold_data    (gold_data),
        .dut_flags    (dut_flags),
        .gold_flags   (gold_flags),
        .cmp_valid    (cmp_valid),
        .cmp_mismatch (cmp_mismatch),
        .cmp_fields   (cmp_fields),
        .cmp_idx      (cmp_idx),
        .cmp_op       (cmp_op)
    );

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        acc_cnt_d = acc_cnt_q;
        match_d   = match_q;
        mism_d    = mism_q;
        fields_d  = fields_q;
        ffv_d     = ffv_q;
        ffidx_d   = ffidx_q;
        ffop_d    = ffop_q;

        // Retire the compare accepted on the previous edge.
        if (cmp_valid) begin
            if (cmp_mismatch) begin
                mism_d   = mism_q + 16'd1;
                fields_d = fields_q | cmp_fields;
                if (!ffv_q) begin
                    ffv_d   = 1'b1;
                    ffidx_d = cmp_idx;
                    ffop_d  = cmp_op;
                end
            end else begin
                match_d = match_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d     = num_vectors;
                    acc_cnt_d = '0;
                    match_d   = '0;
                    mism_d    = '0;
                    fields_d  = '0;
                    ffv_d     = 1'b0;
                    ffidx_d   = '0;
                    ffop_d    = '0;
                    state_d   = (num_vectors == 16'd0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    acc_cnt_d = acc_cnt_q + 16'd1;
                    if (acc_cnt_q == num_q - 16'd1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            acc_cnt_q <= '0;
            match_q   <= '0;
            mism_q    <= '0;
            fields_q  <= '0;
            ffv_q     <= 1'b0;
            ffidx_q   <= '0;
            ffop_q    <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            acc_cnt_q <= acc_cnt_d;
            match_q   <= match_d;
            mism_q    <= mism_d;
            fields_q  <= fields_d;
            ffv_q     <= ffv_d;
            ffidx_q   <= ffidx_d;
            ffop_q    <= ffop_d;
        end
    end

    assign in_ready         = (state_q == ST_RUN);
    assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (mism_q == 16'd0);
    assign match_count      = match_q;
    assign mismatch_count   = mism_q;
    assign fail_fields      = fields_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffidx_q;
    assign first_fail_op    = ffop_q;
    assign state_dbg        = state_q;
endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized and directed runs of alu_result_checker checked against a
// vector-list reference model of the run summary.
module tb_alu_result_checker;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vectors;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [7:0]  dut_data, gold_data;
    logic [3:0]  dut_flags, gold_flags;
    logic [15:0] match_count, mismatch_count;
    logic [4:0]  fail_fields;
    logic        first_fail_valid;
    logic [15:0] first_fail_idx;
    logic [2:0]  first_fail_op;
    logic        busy, done, pass;
    logic [1:0]  state_dbg;

    int n_total = 0;
    int n_bad   = 0;
    int ready_cycles;

    logic [2:0]  v_op[$];
    logic [7:0]  v_dd[$], v_gd[$];
    logic [3:0]  v_df[$], v_gf[$];
    logic [15:0] exp_q[$];

    alu_result_checker #(.WIDTH(8), .OPCODE(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .dut_data(dut_data), .gold_data(gold_data),
        .dut_flags(dut_flags), .gold_flags(gold_flags),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .fail_fields(fail_fields), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx), .first_fail_op(first_fail_op),
        .busy(busy), .done(done), .pass(pass), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic gen_vectors(input int n, input int mm_pct);
        v_op.delete(); v_dd.delete(); v_gd.delete(); v_df.delete(); v_gf.delete();
        for (int i = 0; i < n; i++) begin
            logic [7:0] g;
            logic [3:0] gf;
            logic [7:0] d;
            logic [3:0] df;
            g  = 8'($urandom);
            gf = 4'($urandom);
            d  = g;
            df = gf;
            if ($urandom_range(99) < mm_pct) begin
                if ($urandom_range(4) == 4) d = g ^ 8'($urandom_range(255, 1));
                else df = gf ^ 4'($urandom_range(15, 1));
            end
            v_op.push_back(3'($urandom));
            v_gd.push_back(g);
            v_dd.push_back(d);
            v_gf.push_back(gf);
            v_df.push_back(df);
        end
    endtask

    // Reference model: summarise the vector list straight from the comparison rules.
    task automatic model_push(input int n);
        int m = 0, mm = 0;
        logic [4:0]  fields = '0;
        logic        ffv = 1'b0;
        logic [15:0] fidx = '0;
        logic [2:0]  fop = '0;
        for (int i = 0; i < n; i++) begin
            logic [4:0] f;
            f = {v_dd[i] != v_gd[i], v_df[i] ^ v_gf[i]};
            if (f != 5'd0) begin
                mm++;
                fields = fields | f;
                if (!ffv) begin
                    ffv = 1'b1; fidx = 16'(i); fop = v_op[i];
                end
            end else begin
                m++;
            end
        end
        exp_q.push_back(16'(m));
        exp_q.push_back(16'(mm));
        exp_q.push_back({11'd0, fields});
        exp_q.push_back({15'd0, ffv});
        exp_q.push_back(fidx);
        exp_q.push_back({13'd0, fop});
        exp_q.push_back({15'd0, mm == 0});
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1;
        num_vectors = 16'(n);
        @(negedge clk);
        start = 1'b0;
        num_vectors = 16'($urandom);
    endtask

    // Called at a negedge just after start; returns at the negedge after `limit` accepts.
    task automatic drive_pairs(input int limit, input int stall_pct, input int gap, input int poke_cyc);
        int i = 0;
        int cyc = 0;
        int gap_left = 0;
        ready_cycles = 0;
        while (i < limit && cyc < 2000) begin
            if (gap_left > 0 || $urandom_range(99) < stall_pct) begin
                in_valid = 1'b0;
                in_op = 3'($urandom); dut_data = 8'($urandom); gold_data = 8'($urandom);
                dut_flags = 4'($urandom); gold_flags = 4'($urandom);
                if (gap_left > 0) gap_left--;
            end else begin
                in_valid = 1'b1;
                in_op = v_op[i]; dut_data = v_dd[i]; gold_data = v_gd[i];
                dut_flags = v_df[i]; gold_flags = v_gf[i];
            end
            start = (cyc == poke_cyc);
            num_vectors = 16'($urandom);
            if (in_ready) ready_cycles++;
            if (in_valid && in_ready) begin
                i++;
                gap_left = gap;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (i < limit) check_eq("accept_timeout", 32'(i), 32'(limit));
    endtask

    task automatic finish_and_check(input string tag);
        logic [1:0] drain_dbg;
        check_eq({tag, "_drain_busy"}, {31'd0, busy}, 32'd1);
        check_eq({tag, "_drain_done"}, {31'd0, done}, 32'd0);
        drain_dbg = state_dbg;
        @(negedge clk);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_dbg_moved"}, {31'd0, state_dbg != drain_dbg}, 32'd1);
        // Pairs offered while not ready must not count.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            dut_data = 8'($urandom); gold_data = ~dut_data;
            @(negedge clk);
            check_eq({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check_eq({tag, "_match"},    32'(match_count),      32'(exp_q.pop_front()));
        check_eq({tag, "_mismatch"}, 32'(mismatch_count),   32'(exp_q.pop_front()));
        check_eq({tag, "_fields"},   32'(fail_fields),      32'(exp_q.pop_front()));
        check_eq({tag, "_ffv"},      32'(first_fail_valid), 32'(exp_q.pop_front()));
        check_eq({tag, "_ffidx"},    32'(first_fail_idx),   32'(exp_q.pop_front()));
        check_eq({tag, "_ffop"},     32'(first_fail_op),    32'(exp_q.pop_front()));
        check_eq({tag, "_pass"},     32'(pass),             32'(exp_q.pop_front()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"},  {31'd0, done}, 32'd0);
        check_eq({tag, "_pass"},  {31'd0, pass}, 32'd0);
        check_eq({tag, "_cnts"},  {match_count, mismatch_count}, 32'd0);
        check_eq({tag, "_ff"},    {8'd0, fail_fields, first_fail_valid, first_fail_idx, first_fail_op}, 32'd0);
    endtask

    // scoreboard-driven main sequence
    initial begin
        rst_n = 1'b0; start = 1'b0; num_vectors = '0; in_valid = 1'b0;
        in_op = '0; dut_data = '0; gold_data = '0; dut_flags = '0; gold_flags = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("reset");

        // Four identical pairs, in_valid held high.
        gen_vectors(4, 0);
        model_push(4);
        pulse_start(4);
        drive_pairs(4, 0, 0, -1);
        check_eq("basic_ready_cycles", 32'(ready_cycles), 32'd4);
        finish_and_check("basic");

        // Data mismatch on vector 1.
        gen_vectors(3, 0);
        v_dd[1] = 8'h5A; v_gd[1] = 8'h5B; v_op[1] = 3'h2;
        model_push(3);
        pulse_start(3);
        drive_pairs(3, 0, 0, -1);
        finish_and_check("data_mm");

        // Carry mismatch on vector 0, slt mismatch on vector 2.
        gen_vectors(3, 0);
        v_df[0] = v_gf[0] ^ 4'b1000;
        v_df[2] = v_gf[2] ^ 4'b0001;
        model_push(3);
        pulse_start(3);
        drive_pairs(3, 0, 0, -1);
        finish_and_check("flag_mm");

        // Stall gaps between pairs and a start pulse mid-run.
        gen_vectors(2, 0);
        model_push(2);
        pulse_start(2);
        drive_pairs(2, 0, 5, 3);
        finish_and_check("stall");

        // Zero-length run.
        gen_vectors(0, 0);
        model_push(0);
        pulse_start(0);
        finish_and_check("empty");

        // Reset after 2 of 5 vectors.
        gen_vectors(5, 50);
        pulse_start(5);
        drive_pairs(2, 0, 0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset_hold");
        gen_vectors(1, 0);
        model_push(1);
        pulse_start(1);
        drive_pairs(1, 0, 0, -1);
        finish_and_check("after_reset");

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(12, 1);
            gen_vectors(n, 35);
            model_push(n);
            pulse_start(n);
            drive_pairs(n, $urandom_range(40), 0, $urandom_range(6));
            finish_and_check($sformatf("rand%0d", r));
        end

        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
